// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state encoding and helpers for the FFT sequencer
package fft_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        READ_A,
        READ_B,
        WAIT_RD,
        MUL,
        ADDSUB,
        WRITE_A,
        WRITE_B,
        DONE,
        DUMP
    } state_t;

    // Reverse the low w bits of v; bits above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[i] = v[w-1-i];
        end
        return r;
    endfunction

    // Cycles spent on one butterfly: two reads, two writes, plus pipeline latencies.
    function automatic int calc_t(input int rd_lat, input int mul_lat, input int add_lat);
        return 4 + rd_lat + mul_lat + add_lat;
    endfunction

endpackage

// File: rtl/fft_agu.sv
// rtl/fft_agu.sv - registered butterfly address and twiddle index generator
module fft_agu #(
    parameter int LOG2N = 4,
    parameter int SW    = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [SW-1:0]    stage,
    input  logic [LOG2N-2:0] bfly,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] twiddle
);

    logic [LOG2N-1:0]   span;
    logic [LOG2N-1:0]   pos;
    logic [LOG2N-1:0]   grp;
    logic [LOG2N-1:0]   a_d;
    logic [2*LOG2N-2:0] tw_full;

    // pos < span, so shifting left by LOG2N-1 then right by stage loses no bits.
    always_comb begin
        span    = LOG2N'(1) << stage;
        pos     = {1'b0, bfly} & (span - LOG2N'(1));
        grp     = {1'b0, bfly} >> stage;
        a_d     = ((grp << stage) << 1) | pos;
        tw_full = {pos, {(LOG2N-1){1'b0}}} >> stage;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_a  <= '0;
            addr_b  <= '0;
            twiddle <= '0;
        end else begin
            addr_a  <= a_d;
            addr_b  <= a_d + span;
            twiddle <= tw_full[LOG2N-2:0];
        end
    end

endmodule

// File: rtl/fft_seq_ctrl.sv
// rtl/fft_seq_ctrl.sv - in-place radix-2 DIT FFT sequencer over a single-port sample RAM
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N   = 4,
    parameter int RD_LAT  = 1,
    parameter int MUL_LAT = 3,
    parameter int ADD_LAT = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       inverse_i,
    input  logic                       load_valid_i,
    output logic                       load_ready_o,
    input  logic                       read_ram_i,
    output logic [LOG2N-1:0]           mem_addr_o,
    output logic                       mem_re_o,
    output logic                       mem_we_o,
    output logic                       mem_sel_b_o,
    output logic [LOG2N-2:0]           twiddle_idx_o,
    output logic                       inverse_o,
    output logic                       mul_en_o,
    output logic                       addsub_en_o,
    output logic [$clog2(LOG2N)-1:0]   stage_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int SW = $clog2(LOG2N);
    localparam int WW = $clog2(calc_t(RD_LAT, MUL_LAT, ADD_LAT));
    localparam logic [LOG2N-2:0] LAST_BFLY  = '1;
    localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG2N - 1);

    state_t           state_q, state_d;
    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic [LOG2N-2:0] bfly_q, bfly_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             inv_q, inv_d;
    logic [LOG2N-1:0] addr_a, addr_b;
    logic [LOG2N-2:0] twiddle;

    // The AGU registers the next counter values so its outputs line up with bfly_q/stage_q.
    fft_agu #(
        .LOG2N (LOG2N),
        .SW    (SW)
    ) u_agu (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .stage   (stage_d),
        .bfly    (bfly_d),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .twiddle (twiddle)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bfly_q  <= '0;
            stage_q <= '0;
            wait_q  <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bfly_q  <= bfly_d;
            stage_q <= stage_d;
            wait_q  <= wait_d;
            inv_q   <= inv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bfly_d  = bfly_q;
        stage_d = stage_q;
        wait_d  = wait_q;
        inv_d   = inv_q;
        unique case (state_q)
            IDLE: begin
                if (read_ram_i) begin
                    state_d = DUMP;
                end else if (start_i) begin
                    state_d = LOAD;
                    inv_d   = inverse_i;
                end
            end
            LOAD: begin
                if (load_valid_i) begin
                    cnt_d = cnt_q + LOG2N'(1);
                    if (cnt_q == '1) state_d = READ_A;
                end
            end
            READ_A: state_d = READ_B;
            READ_B: begin
                state_d = WAIT_RD;
                wait_d  = WW'(RD_LAT - 1);
            end
            WAIT_RD: begin
                if (wait_q == '0) begin
                    state_d = MUL;
                    wait_d  = WW'(MUL_LAT - 1);
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            MUL: begin
                if (wait_q == '0) begin
                    state_d = ADDSUB;
                    wait_d  = WW'(ADD_LAT - 1);
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            ADDSUB: begin
                if (wait_q == '0) state_d = WRITE_A;
                else              wait_d  = wait_q - WW'(1);
            end
            WRITE_A: state_d = WRITE_B;
            WRITE_B: begin
                state_d = READ_A;
                if (bfly_q != LAST_BFLY) begin
                    bfly_d = bfly_q + (LOG2N-1)'(1);
                end else if (stage_q != LAST_STAGE) begin
                    bfly_d  = '0;
                    stage_d = stage_q + SW'(1);
                end else begin
                    bfly_d  = '0;
                    stage_d = '0;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            DUMP: begin
                if (read_ram_i) begin
                    cnt_d = cnt_q + LOG2N'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ready_o  = (state_q == LOAD);
        mem_re_o      = (state_q == READ_A) || (state_q == READ_B) || (state_q == DUMP);
        mem_we_o      = ((state_q == LOAD) && load_valid_i) ||
                        (state_q == WRITE_A) || (state_q == WRITE_B);
        mem_sel_b_o   = (state_q == READ_B) || (state_q == WRITE_B);
        mul_en_o      = (state_q == MUL);
        addsub_en_o   = (state_q == ADDSUB);
        busy_o        = (state_q != IDLE);
        done_o        = (state_q == DONE);
        inverse_o     = inv_q;
        stage_o       = stage_q;
        twiddle_idx_o = (state_q inside {READ_A, READ_B, WAIT_RD, MUL, ADDSUB, WRITE_A, WRITE_B})
                        ? twiddle : '0;
        unique case (state_q)
            LOAD:             mem_addr_o = LOG2N'(bitrev(32'(cnt_q), LOG2N));
            READ_A, WRITE_A:  mem_addr_o = addr_a;
            READ_B, WRITE_B:  mem_addr_o = addr_b;
            DUMP:             mem_addr_o = cnt_q;
            default:          mem_addr_o = '0;
        endcase
    end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb/tb_fft_seq_ctrl.sv - scoreboard bench for the FFT sequencer
module tb_fft_seq_ctrl;

    localparam int LOG2N   = 4;
    localparam int RD_LAT  = 1;
    localparam int MUL_LAT = 3;
    localparam int ADD_LAT = 1;
    localparam int N       = 1 << LOG2N;
    localparam int NBF     = LOG2N * (N / 2);
    localparam int TB      = 4 + RD_LAT + MUL_LAT + ADD_LAT;

    typedef struct {
        bit               re;
        bit               we;
        bit               sel_b;
        logic [LOG2N-1:0] addr;
        logic [LOG2N-2:0] tw;
        bit               tw_chk;
        bit               first;
        bit               comp;
    } op_t;

    logic             clk_i = 0;
    logic             rst_ni = 0;
    logic             start_i = 0;
    logic             inverse_i = 0;
    logic             load_valid_i = 0;
    logic             read_ram_i = 0;
    logic             load_ready_o;
    logic [LOG2N-1:0] mem_addr_o;
    logic             mem_re_o, mem_we_o, mem_sel_b_o;
    logic [LOG2N-2:0] twiddle_idx_o;
    logic             inverse_o, mul_en_o, addsub_en_o;
    logic [1:0]       stage_o;
    logic             busy_o, done_o;
    logic [31:0]      all_outs;

    int  checks = 0;
    int  failures = 0;
    op_t exp_q[$];
    bit  done_q[$];

    fft_seq_ctrl #(
        .LOG2N(LOG2N), .RD_LAT(RD_LAT), .MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .inverse_i(inverse_i),
        .load_valid_i(load_valid_i), .load_ready_o(load_ready_o), .read_ram_i(read_ram_i),
        .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
        .mem_sel_b_o(mem_sel_b_o), .twiddle_idx_o(twiddle_idx_o), .inverse_o(inverse_o),
        .mul_en_o(mul_en_o), .addsub_en_o(addsub_en_o), .stage_o(stage_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    assign all_outs = 32'({load_ready_o, mem_addr_o, mem_re_o, mem_we_o, mem_sel_b_o,
                           twiddle_idx_o, inverse_o, mul_en_o, addsub_en_o, stage_o,
                           busy_o, done_o});

    always #5 clk_i = ~clk_i;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic op_t mk(input bit re, input bit we, input bit sel, input int addr,
                               input int tw, input bit chk, input bit first, input bit comp);
        op_t o;
        o.re = re; o.we = we; o.sel_b = sel;
        o.addr = LOG2N'(addr); o.tw = (LOG2N-1)'(tw);
        o.tw_chk = chk; o.first = first; o.comp = comp;
        return o;
    endfunction

    function automatic int rev(input int v);
        int r = 0;
        int x = v;
        for (int i = 0; i < LOG2N; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    // Reference access sequence: natural loop over stages, groups and positions.
    task automatic push_run(input bit inv);
        int span, a, tw;
        for (int i = 0; i < N; i++) exp_q.push_back(mk(0, 1, 0, rev(i), 0, 0, 0, 0));
        for (int s = 0; s < LOG2N; s++) begin
            span = 1 << s;
            for (int g = 0; g < N / (2 * span); g++) begin
                for (int p = 0; p < span; p++) begin
                    a  = g * 2 * span + p;
                    tw = p * (N / (2 * span));
                    exp_q.push_back(mk(1, 0, 0, a,        tw, 1, (s == 0 && g == 0 && p == 0), 1));
                    exp_q.push_back(mk(1, 0, 1, a + span, tw, 1, 0, 1));
                    exp_q.push_back(mk(0, 1, 0, a,        tw, 1, 0, 1));
                    exp_q.push_back(mk(0, 1, 1, a + span, tw, 1, 0, 1));
                end
            end
        end
        done_q.push_back(inv);
    endtask

    task automatic do_load(input int gap_mode, input bit inv);
        int acc = 0;
        int guard = 0;
        int ready_bad = 0;
        bit v;
        while (acc < N && guard < 500) begin
            @(posedge clk_i); #1;
            start_i   = 0;
            inverse_i = ~inv;
            if (!load_ready_o) ready_bad++;
            v = (gap_mode == 0) ? ((guard % 3) != 2) : ($urandom_range(0, 3) != 0);
            load_valid_i = v;
            if (v) acc++;
            guard++;
        end
        @(posedge clk_i); #1;
        load_valid_i = 0;
        check(acc == N, "load_accepts", acc, N);
        check(ready_bad == 0, "load_ready_during_load", ready_bad, 0);
        check(!load_ready_o && busy_o, "load_exit_after_n", {load_ready_o, busy_o}, 1);
    endtask

    task automatic run_fft(input bit inv, input int gap_mode, input bit abort);
        int g = 0;
        push_run(inv);
        @(posedge clk_i); #1;
        start_i   = 1;
        inverse_i = inv;
        do_load(gap_mode, inv);
        if (abort) begin
            while (!(stage_o == 2 && mul_en_o) && g < 2000) begin
                @(negedge clk_i); g++;
            end
            check(g < 2000, "reach_stage2_mul", g, 0);
            rst_ni = 0;
            #1;
            check(all_outs == 0, "outs_zero_in_reset", all_outs, 0);
            exp_q.delete();
            done_q.delete();
            @(posedge clk_i); #1;
            rst_ni = 1;
        end else begin
            while (!done_o && g < 2000) begin
                @(negedge clk_i); g++;
            end
            check(g < 2000, "done_timeout", g, 0);
            repeat (3) @(posedge clk_i);
        end
    endtask

    // Monitor: pops one expected access per RAM strobe and checks run-level totals on done.
    int  cyc = 0;
    int  t0 = 0;
    int  we_cnt = 0;
    int  mul_cnt = 0;
    bit  done_low_chk = 0;
    logic [LOG2N-2:0] cur_tw = '0;
    op_t e;
    bit  inv_exp;

    always @(negedge clk_i) begin
        cyc++;
        if (!rst_ni) begin
            we_cnt = 0; mul_cnt = 0; done_low_chk = 0;
        end else begin
            if (done_low_chk) begin
                check(!done_o, "done_one_cycle", done_o, 0);
                done_low_chk = 0;
            end
            if (mem_re_o || mem_we_o) begin
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_access", {mem_re_o, mem_we_o, mem_sel_b_o, mem_addr_o}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({mem_re_o, mem_we_o, mem_sel_b_o, mem_addr_o} == {e.re, e.we, e.sel_b, e.addr},
                          "access_re_we_sel_addr",
                          {mem_re_o, mem_we_o, mem_sel_b_o, mem_addr_o}, {e.re, e.we, e.sel_b, e.addr});
                    if (e.tw_chk) begin
                        check(twiddle_idx_o == e.tw, "twiddle_at_access", twiddle_idx_o, e.tw);
                        cur_tw = e.tw;
                    end
                    if (e.first) t0 = cyc;
                    if (e.comp && e.we) we_cnt++;
                end
            end
            if (mul_en_o || addsub_en_o) begin
                check(twiddle_idx_o == cur_tw, "twiddle_hold", twiddle_idx_o, cur_tw);
                if (mul_en_o) mul_cnt++;
            end
            if (done_o) begin
                if (done_q.size() == 0) begin
                    check(0, "unexpected_done", 1, 0);
                end else begin
                    inv_exp = done_q.pop_front();
                    check(cyc - t0 == NBF * TB, "compute_latency", cyc - t0, NBF * TB);
                    check(inverse_o == inv_exp, "inverse_captured", inverse_o, inv_exp);
                    check(we_cnt == 2 * NBF, "compute_we_pulses", we_cnt, 2 * NBF);
                    check(mul_cnt == NBF * MUL_LAT, "mul_cycles", mul_cnt, NBF * MUL_LAT);
                end
                we_cnt = 0; mul_cnt = 0;
                done_low_chk = 1;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check(all_outs == 0, "idle_after_reset", all_outs, 0);
        end

        run_fft(1, 0, 0);

        // start_i and read_ram_i together: read-out wins and start is ignored.
        @(posedge clk_i); #1;
        start_i    = 1;
        read_ram_i = 1;
        for (int i = 0; i < 18; i++) exp_q.push_back(mk(1, 0, 0, i % N, 0, 0, 0, 0));
        repeat (18) @(posedge clk_i);
        #1;
        start_i    = 0;
        read_ram_i = 0;
        @(posedge clk_i); #1;
        check(!busy_o && !load_ready_o, "dump_exit_idle", {busy_o, load_ready_o}, 0);
        check(exp_q.size() == 0, "dump_reads_consumed", exp_q.size(), 0);

        run_fft($urandom_range(0, 1), 1, 1);
        run_fft(0, 1, 0);

        check(exp_q.size() == 0, "leftover_accesses", exp_q.size(), 0);
        check(done_q.size() == 0, "leftover_done", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_seq_ctrl.md
Name: fft_seq_ctrl

Overview:
- Parametrised sequencer for an in-place radix-2 DIT FFT over a single-port sample RAM.
- Covers sample load in bit-reversed order, all stages and butterflies with internally generated addresses and twiddle indices, configurable pipeline latencies, forward/inverse mode, and natural-order read-out.
- Replaces the external end-of-phase strobes of the previous controller with internal counters.
- Sits between the bus/sample interface and the FFT datapath (RAM, complex multiplier, add/sub unit, twiddle ROM).

Parameters:
- LOG2N, 4, log2 of FFT points N (N = 2**LOG2N, LOG2N >= 2).
- RD_LAT, 1, RAM read latency in cycles (>= 1).
- MUL_LAT, 3, complex multiplier latency in cycles (>= 1).
- ADD_LAT, 1, add/sub latency in cycles (>= 1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  begin load+compute; sampled in IDLE only.
- inverse_i  in  1  mode select, captured when start_i is accepted.
- load_valid_i  in  1  input sample valid.
- load_ready_o  out  1  controller accepts samples (LOAD state).
- read_ram_i  in  1  level request for natural-order read-out.
- mem_addr_o  out  LOG2N  RAM address.
- mem_re_o  out  1  RAM read enable.
- mem_we_o  out  1  RAM write enable.
- mem_sel_b_o  out  1  0 = A operand/result, 1 = B.
- twiddle_idx_o  out  LOG2N-1  twiddle ROM index.
- inverse_o  out  1  captured mode; datapath conjugates twiddles.
- mul_en_o  out  1  multiplier stage enable.
- addsub_en_o  out  1  add/sub stage enable.
- stage_o  out  $clog2(LOG2N)  current stage.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE, all counters 0, inverse_o 0, and every output 0.
- Outputs decode only from state and counter registers. The sole combinational path is mem_we_o = load_valid_i in LOAD.
- IDLE:
  - read_ram_i takes priority → DUMP.
  - Otherwise start_i → LOAD, capturing inverse_i.
- LOAD:
  - load_ready_o = 1.
  - Each cycle with load_valid_i: write at mem_addr_o = bitrev(sample_cnt), then sample_cnt++.
  - Gaps in load_valid_i are allowed.
  - After the N-th accepted sample → READ_A with stage = 0, bfly = 0.
- Address generation for stage s and butterfly k (0..N/2-1):
  - span = 1<<s; grp = k>>s; pos = k & (span-1).
  - addr_a = (grp<<(s+1)) | pos; addr_b = addr_a + span.
  - twiddle = pos<<(LOG2N-1-s).
  - All values are unsigned and truncated to port width.
- Per-butterfly sequence:
  - READ_A (1 cycle): re=1, sel_b=0, addr_a.
  - READ_B (1 cycle): re=1, sel_b=1, addr_b.
  - WAIT_RD (RD_LAT cycles).
  - MUL (MUL_LAT cycles): mul_en=1, twiddle valid.
  - ADDSUB (ADD_LAT cycles): addsub_en=1.
  - WRITE_A (1 cycle): we=1, sel_b=0, addr_a.
  - WRITE_B (1 cycle): we=1, sel_b=1, addr_b.
  - Cycles per butterfly T = 4 + RD_LAT + MUL_LAT + ADD_LAT.
  - twiddle_idx_o is held stable from READ_A through WRITE_B.
- After WRITE_B:
  - bfly < N/2-1: bfly++ → READ_A.
  - bfly = N/2-1 and stage < LOG2N-1: bfly = 0, stage++ → READ_A.
  - Otherwise → DONE.
- DONE (1 cycle): done_o = 1 → IDLE.
- DUMP:
  - re=1; address starts at 0 and increments each cycle, wrapping N-1 → 0.
  - read_ram_i low → IDLE with the address counter cleared.
- Latency: compute phase lasts LOG2N·(N/2)·T cycles from the first READ_A to DONE.
- start_i and read_ram_i are ignored outside IDLE.
- Reset asserted mid-operation: immediate return to IDLE with all counters cleared; RAM contents are don't-care.
- Latency wait states use one shared down-counter loaded on state entry.

Decomposition:
- fft_pkg holds:
  - state enum (IDLE, LOAD, READ_A, READ_B, WAIT_RD, MUL, ADDSUB, WRITE_A, WRITE_B, DONE, DUMP);
  - bitrev function;
  - T-calculation constant function.
- One sub-module, fft_agu: registered address-generation unit taking stage/bfly and producing addr_a, addr_b, twiddle.
  - It updates on bfly/stage change and is ready before the next READ_A.

Test Plan:
- Reset, then idle 5 cycles → all outputs 0 and busy_o 0.
- Defaults, start_i, load 16 samples with valid deasserted every 3rd cycle:
  - → write addresses 0,8,4,12,2,10,…,15;
  - → LOAD exits after exactly 16 accepts.
- Address checks (defaults):
  - stage 0, k=0 → addr 0/1, twiddle 0;
  - stage 1, k=3 → addr 5/7, twiddle 4;
  - stage 3, k=5 → addr 5/13, twiddle 5.
- Full run (defaults, T=9):
  - → 288 cycles from first READ_A to done_o;
  - → done_o high exactly 1 cycle;
  - → 64 we pulses in compute;
  - → inverse_o equals inverse_i captured at start.
- start_i and read_ram_i asserted together in IDLE → DUMP; hold 18 cycles → addresses 0..15,0,1; deassert → IDLE.
- Assert rst_ni low during stage 2 MUL → all outputs 0 immediately; after release a new start_i completes normally in 288 compute cycles.
